// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, error codes, header size.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_WORD   = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    // Number of big-endian length bytes that precede the word payload.
    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words and keeps a running XOR of every packed byte.
// Latency: assembled word is combinational with the 4th byte; checksum updates on the accepting edge.
// Backpressure: none; consumes a byte on every cycle shift is high.
//
// Ports: clk, reset (async active-low), clr (restart packing and checksum),
//        shift (accept din), din, word_done (4th byte of a word is on din this cycle),
//        word (assembled word including din), csum (XOR of all bytes shifted so far).
module loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic        word_done,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  byte_cnt_q;
    logic [23:0] shreg_q;
    logic [7:0]  csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_q <= 2'd0;
            shreg_q    <= 24'd0;
            csum_q     <= 8'd0;
        end else if (clr) begin
            byte_cnt_q <= 2'd0;
            shreg_q    <= 24'd0;
            csum_q     <= 8'd0;
        end else if (shift) begin
            // Counter wraps 3 -> 0 on its own, ready for the next word.
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shreg_q    <= {shreg_q[15:0], din};
            csum_q     <= csum_q ^ din;
        end
    end

    // Only three bytes are stored; the fourth is taken straight from din so the
    // word can be registered into the memory port on the same edge.
    assign word      = {shreg_q, din};
    assign word_done = shift && (byte_cnt_q == 2'd3);
    assign csum      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and holds the core in reset until it verifies.
// Latency: memory write one cycle after the 4th byte of a word; done one cycle after the checksum byte.
// Backpressure: in_ready high in every active state; an accepted byte is never stalled.
//
// Ports: clk, reset (async active-low), start/abort pulses, in_valid/in_data/in_ready byte stream,
//        mem_we/mem_addr/mem_wdata memory write port, cpu_reset, busy, done, error, err_code.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [31:0] MAX_WORDS_U = MAX_WORDS;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [15:0]       n_words_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic              we_pend_q;
    logic              cpu_rst_q;

    logic              fire, wshift, sess_start, sess_abort;
    logic [15:0]       len_in;
    logic              len_too_big, last_word;
    logic              word_done;
    logic [31:0]       word_asm;
    logic [7:0]        csum;

    assign len_in      = {len_hi_q, in_data};
    assign len_too_big = {16'd0, len_in} > MAX_WORDS_U;
    assign last_word   = (32'(word_idx_q) + 32'd1) == {16'd0, n_words_q};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LEN_HI;
            ST_LEN_HI: if (fire)  state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (fire) begin
                    if (len_in == 16'd0)  state_d = ST_CHECK;
                    else if (len_too_big) state_d = ST_IDLE;
                    else                  state_d = ST_WORD;
                end
            end
            ST_WORD:   if (fire && word_done && last_word) state_d = ST_CHECK;
            ST_CHECK:  if (fire) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (sess_abort) state_d = ST_IDLE;
    end

    // Output / decode logic
    always_comb begin
        in_ready   = (state_q != ST_IDLE);
        busy       = (state_q != ST_IDLE);
        sess_start = start && (state_q == ST_IDLE);
        sess_abort = abort && (state_q != ST_IDLE);
        // abort beats a byte offered in the same cycle
        fire       = in_valid && in_ready && !abort;
        wshift     = fire && (state_q == ST_WORD);
    end

    loader_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (sess_start),
        .shift     (wshift),
        .din       (in_data),
        .word_done (word_done),
        .word      (word_asm),
        .csum      (csum)
    );

    // Datapath and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_q   <= 8'd0;
            n_words_q  <= 16'd0;
            word_idx_q <= '0;
            we_pend_q  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_rst_q  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            we_pend_q <= 1'b0;
            done      <= 1'b0;
            // Core leaves reset the cycle after the done pulse; a start in that
            // same cycle takes priority because it is assigned later below.
            if (done) cpu_rst_q <= 1'b0;

            if (sess_start) begin
                error      <= 1'b0;
                err_code   <= ERR_NONE;
                cpu_rst_q  <= 1'b1;
                word_idx_q <= '0;
            end else if (sess_abort) begin
                error     <= 1'b1;
                err_code  <= ERR_ABORT;
                cpu_rst_q <= 1'b1;
            end else if (fire) begin
                case (state_q)
                    ST_LEN_HI: len_hi_q <= in_data;
                    ST_LEN_LO: begin
                        n_words_q <= len_in;
                        if (len_too_big) begin
                            error    <= 1'b1;
                            err_code <= ERR_LEN;
                        end
                    end
                    ST_WORD: begin
                        if (word_done) begin
                            we_pend_q <= 1'b1;
                            mem_addr  <= word_idx_q;
                            mem_wdata <= word_asm;
                            // Stop at the last index so the counter cannot wrap.
                            if (!last_word) word_idx_q <= word_idx_q + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (in_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A write strobe still pending when abort arrives is dropped.
    assign mem_we    = we_pend_q && !abort;
    assign cpu_reset = cpu_rst_q;

endmodule
